// File: rtl/csr_file.sv
// Machine-mode CSR register file for the RV32I single-cycle core.
// Holds mstatus (MIE/MPIE), misa (constant), mtvec, mscratch, mepc, mcause
// and the 64-bit mcycle/minstret counters with their user-mode read-only aliases.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   csr_w, csr_data_s, data_read_sel, f3, csr_addr, rs1_data, uimm
//                                   CSR instruction decode from the control unit
//   instr_retire                    instruction retires this cycle
//   trap_req, trap_cause, trap_pc   trap entry request and its cause/PC
//   mret                            return from trap
//   csr_rdata, illegal_csr          combinational read data / illegal-access flag
//   trap_vector, epc, mie           register outputs to the PC logic
module csr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_w,
  input  logic        csr_data_s,
  input  logic        data_read_sel,
  input  logic [1:0]  f3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic        instr_retire,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic [31:0] trap_vector,
  output logic [31:0] epc,
  output logic        mie
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 64;
  localparam int unsigned UW   = 5;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic            mie_q;
  logic            mpie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [CW-1:0]   mcycle_q;
  logic [CW-1:0]   minstret_q;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_val;
  logic            mapped;
  logic            wr_eff;
  logic            commit;
  logic [CW-1:0]   mcycle_nxt;
  logic [CW-1:0]   minstret_nxt;

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  // Address decode: old value and whether the address exists at all.
  always_comb begin
    old_val = '0;
    mapped  = 1'b0;
    case (csr_addr)
      ADDR_MSTATUS:                begin old_val = mstatus_val;        mapped = 1'b1; end
      ADDR_MISA:                   begin old_val = MISA_VAL;           mapped = 1'b1; end
      ADDR_MTVEC:                  begin old_val = mtvec_q;            mapped = 1'b1; end
      ADDR_MSCRATCH:               begin old_val = mscratch_q;         mapped = 1'b1; end
      ADDR_MEPC:                   begin old_val = mepc_q;             mapped = 1'b1; end
      ADDR_MCAUSE:                 begin old_val = mcause_q;           mapped = 1'b1; end
      ADDR_MCYCLE,   ADDR_CYCLE:   begin old_val = mcycle_q[31:0];     mapped = 1'b1; end
      ADDR_MCYCLEH,  ADDR_CYCLEH:  begin old_val = mcycle_q[63:32];    mapped = 1'b1; end
      ADDR_MINSTRET, ADDR_INSTRET: begin old_val = minstret_q[31:0];   mapped = 1'b1; end
      ADDR_MINSTRETH, ADDR_INSTRETH: begin old_val = minstret_q[63:32]; mapped = 1'b1; end
      default: ;
    endcase
  end

  // Write source, read-modify-write value and commit qualification.
  always_comb begin
    src = csr_data_s ? {{(XLEN-UW){1'b0}}, uimm} : rs1_data;
    case (f3)
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
    // RS/RC with a zero source never write, so they may touch read-only CSRs.
    wr_eff      = csr_w & (f3 != 2'b00) & ((f3 == 2'b01) | (src != '0));
    illegal_csr = csr_w & (~mapped | ((csr_addr[11:10] == 2'b11) & wr_eff));
    commit      = wr_eff & ~illegal_csr & ~trap_req;
    csr_rdata   = data_read_sel ? old_val : '0;
  end

  // Counter next state: a half-word write replaces that half and freezes the whole counter.
  always_comb begin
    mcycle_nxt   = mcycle_q + CW'(1);
    minstret_nxt = minstret_q + CW'(instr_retire & ~trap_req);
    if (commit) begin
      case (csr_addr)
        ADDR_MCYCLE:    mcycle_nxt   = {mcycle_q[63:32], new_val};
        ADDR_MCYCLEH:   mcycle_nxt   = {new_val, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_nxt = {minstret_q[63:32], new_val};
        ADDR_MINSTRETH: minstret_nxt = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State update: trap entry over mret over ordinary CSR writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_nxt;
      minstret_q <= minstret_nxt;
      if (trap_req) begin
        mepc_q   <= trap_pc & ALIGN_MASK;
        mcause_q <= trap_cause;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else begin
        if (mret) begin
          mie_q  <= mpie_q;
          mpie_q <= 1'b1;
        end else if (commit && (csr_addr == ADDR_MSTATUS)) begin
          mie_q  <= new_val[3];
          mpie_q <= new_val[7];
        end
        if (commit) begin
          case (csr_addr)
            ADDR_MTVEC:    mtvec_q    <= new_val & ALIGN_MASK;
            ADDR_MSCRATCH: mscratch_q <= new_val;
            ADDR_MEPC:     mepc_q     <= new_val & ALIGN_MASK;
            ADDR_MCAUSE:   mcause_q   <= new_val;
            default: ;
          endcase
        end
      end
    end
  end

  assign trap_vector = mtvec_q & ALIGN_MASK;
  assign epc         = mepc_q;
  assign mie         = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: a table of single-cycle CSR operations
// plus hand-written sequences for counters, traps, mret and reset.
module tb_csr_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;

  localparam int SEL_RDATA = 0;
  localparam int SEL_ILL   = 1;
  localparam int SEL_TVEC  = 2;
  localparam int SEL_EPC   = 3;
  localparam int SEL_MIE   = 4;

  logic        clk;
  logic        rst_n;
  logic        csr_w;
  logic        csr_data_s;
  logic        data_read_sel;
  logic [1:0]  f3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic        instr_retire;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic        mie;

  csr_file #(.MTVEC_RST(MTVEC_RST), .MISA_VAL(MISA_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .csr_w(csr_w), .csr_data_s(csr_data_s),
    .data_read_sel(data_read_sel), .f3(f3), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .uimm(uimm), .instr_retire(instr_retire),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret(mret), .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
    .trap_vector(trap_vector), .epc(epc), .mie(mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent cycle model: rising edges seen out of reset.
  logic [31:0] cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  f3;
    logic        ds;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  u;
    logic        rsel;
    logic [31:0] rdata;
    logic        ill;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   total;
  int   bad;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      SEL_RDATA: return csr_rdata;
      SEL_ILL:   return {31'b0, illegal_csr};
      SEL_TVEC:  return trap_vector;
      SEL_EPC:   return epc;
      SEL_MIE:   return {31'b0, mie};
      default:   return 32'hDEAD_DEAD;
    endcase
  endfunction

  function automatic vec_t mk(logic [1:0] f, logic ds, logic [11:0] a, logic [31:0] r,
                              logic [4:0] u, logic rs, logic [31:0] rd, logic il);
    vec_t v;
    v.f3 = f; v.ds = ds; v.addr = a; v.rs1 = r; v.u = u; v.rsel = rs; v.rdata = rd; v.ill = il;
    return v;
  endfunction

  task automatic push(string name, int sel, logic [31:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = observe(e.sel);
      total++;
      if (got !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h (t=%0t)", e.name, got, e.val, $time);
      end
    end
  endtask

  // Compare at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_w = 1'b0; csr_data_s = 1'b0; data_read_sel = 1'b1; f3 = 2'b00;
    csr_addr = 12'h000; rs1_data = '0; uimm = '0; instr_retire = 1'b0;
    trap_req = 1'b0; trap_cause = '0; trap_pc = '0; mret = 1'b0;
  endtask

  task automatic rd(logic [11:0] a);
    idle();
    csr_addr = a;
  endtask

  task automatic op(logic [1:0] f, logic ds, logic [11:0] a, logic [31:0] r, logic [4:0] u);
    idle();
    csr_w = 1'b1; f3 = f; csr_data_s = ds; csr_addr = a; rs1_data = r; uimm = u;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b0;

    // Reset values while reset is held.
    #7;
    rd(12'h340);
    push("reset_rdata", SEL_RDATA, 32'h0);
    push("reset_tvec",  SEL_TVEC,  MTVEC_RST);
    push("reset_epc",   SEL_EPC,   32'h0);
    push("reset_mie",   SEL_MIE,   32'h0);
    @(negedge clk);
    drain();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;

    // Cycle counter after ten edges, and its alias.
    rd(12'hB00); push("mcycle_10", SEL_RDATA, cyc); tick();
    rd(12'hC00); push("cycle_alias", SEL_RDATA, cyc); tick();
    rd(12'hB80); push("mcycleh_0", SEL_RDATA, 32'h0); tick();
    rd(12'hB02); push("minstret_0", SEL_RDATA, 32'h0); tick();

    // Table of single-cycle CSR operations; rdata is the pre-write value.
    tbl.push_back(mk(2'b01, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'd0,  1'b1, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 12'h340, 32'h0000_0010, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0));
    tbl.push_back(mk(2'b11, 1'b1, 12'h340, 32'hFFFF_FFFF, 5'h0F, 1'b1, 32'hDEAD_BEFF, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h340, 32'hFFFF_FFFF, 5'd0,  1'b1, 32'hDEAD_BEF0, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h340, 32'h0,         5'd0,  1'b0, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 12'h301, 32'h0000_1234, 5'd0,  1'b1, MISA_VAL,      1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h301, 32'h0,         5'd0,  1'b1, MISA_VAL,      1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 12'h305, 32'h8000_0103, 5'd0,  1'b1, MTVEC_RST,     1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h305, 32'h0,         5'd0,  1'b1, 32'h8000_0100, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 12'h341, 32'h0000_0127, 5'd0,  1'b1, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h341, 32'h0,         5'd0,  1'b1, 32'h0000_0124, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 12'h342, 32'h8000_0007, 5'd0,  1'b1, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h342, 32'h0,         5'd0,  1'b1, 32'h8000_0007, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 12'h7FF, 32'h0000_0005, 5'd0,  1'b1, 32'h0000_0000, 1'b1));
    tbl.push_back(mk(2'b00, 1'b0, 12'h7FF, 32'h0,         5'd0,  1'b1, 32'h0000_0000, 1'b1));
    tbl.push_back(mk(2'b01, 1'b0, 12'h300, 32'hFFFF_FFFF, 5'd0,  1'b1, 32'h0000_1800, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h300, 32'h0,         5'd0,  1'b1, 32'h0000_1888, 1'b0));
    tbl.push_back(mk(2'b11, 1'b1, 12'h300, 32'h0,         5'd8,  1'b1, 32'h0000_1888, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h300, 32'h0,         5'd0,  1'b1, 32'h0000_1880, 1'b0));
    tbl.push_back(mk(2'b00, 1'b0, 12'h300, 32'hFFFF_FFFF, 5'd0,  1'b1, 32'h0000_1880, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'h300, 32'h0,         5'd0,  1'b1, 32'h0000_1880, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'hC80, 32'h0,         5'd0,  1'b1, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'b11, 1'b1, 12'hC02, 32'h0,         5'd0,  1'b1, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 12'hC02, 32'h0,         5'd1,  1'b1, 32'h0000_0000, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      op(tbl[i].f3, tbl[i].ds, tbl[i].addr, tbl[i].rs1, tbl[i].u);
      data_read_sel = tbl[i].rsel;
      push($sformatf("vec%0d_rdata", i), SEL_RDATA, tbl[i].rdata);
      push($sformatf("vec%0d_ill", i),   SEL_ILL,   {31'b0, tbl[i].ill});
      tick();
    end

    idle();
    push("tvec_after_write", SEL_TVEC, 32'h8000_0100);
    push("epc_after_write",  SEL_EPC,  32'h0000_0124);
    push("mie_after_clear",  SEL_MIE,  32'h0);
    tick();

    // Read-only counter alias: zero-source RS legal, RW illegal and harmless.
    op(2'b10, 1'b1, 12'hC00, 32'h0, 5'd0);
    push("cycle_rs0_rdata", SEL_RDATA, cyc); push("cycle_rs0_ill", SEL_ILL, 32'h0); tick();
    op(2'b01, 1'b0, 12'hC00, 32'h0, 5'd0);
    push("cycle_rw_rdata", SEL_RDATA, cyc); push("cycle_rw_ill", SEL_ILL, 32'h1); tick();
    rd(12'hC00); push("cycle_after_rw", SEL_RDATA, cyc); tick();

    // minstret write collides with a retire, then carries into the high word.
    op(2'b01, 1'b0, 12'hB02, 32'hFFFF_FFFF, 5'd0); instr_retire = 1'b1;
    push("minstret_wr_rdata", SEL_RDATA, 32'h0); tick();
    op(2'b10, 1'b1, 12'hB02, 32'h0, 5'd0); instr_retire = 1'b1;
    push("minstret_held", SEL_RDATA, 32'hFFFF_FFFF); tick();
    rd(12'hB82); push("minstreth_carry", SEL_RDATA, 32'h1); tick();
    rd(12'hB02); push("minstret_wrap", SEL_RDATA, 32'h0); tick();
    rd(12'hC82); push("instreth_alias", SEL_RDATA, 32'h1); tick();

    // Trap entry with a simultaneous mscratch write and a retire.
    op(2'b01, 1'b0, 12'h300, 32'h0000_0008, 5'd0);
    push("mstatus_pre", SEL_RDATA, 32'h0000_1880); tick();
    rd(12'h300);
    push("mie_set", SEL_MIE, 32'h1); push("mstatus_mie", SEL_RDATA, 32'h0000_1808); tick();
    op(2'b01, 1'b0, 12'h340, 32'h0000_0055, 5'd0);
    trap_req = 1'b1; trap_cause = 32'h0000_000B; trap_pc = 32'h0000_0126; instr_retire = 1'b1;
    push("trap_cycle_rdata", SEL_RDATA, 32'hDEAD_BEF0); push("trap_cycle_ill", SEL_ILL, 32'h0); tick();
    rd(12'h342);
    push("trap_epc", SEL_EPC, 32'h0000_0124); push("trap_mie", SEL_MIE, 32'h0);
    push("trap_tvec", SEL_TVEC, 32'h8000_0100); push("trap_mcause", SEL_RDATA, 32'h0000_000B); tick();
    rd(12'h300); push("trap_mstatus", SEL_RDATA, 32'h0000_1880); tick();
    rd(12'h340); push("trap_mscratch_kept", SEL_RDATA, 32'hDEAD_BEF0); tick();
    rd(12'h341); push("trap_mepc_rd", SEL_RDATA, 32'h0000_0124); tick();
    rd(12'hB02); push("trap_minstret_lo", SEL_RDATA, 32'h0); tick();
    rd(12'hB82); push("trap_minstret_hi", SEL_RDATA, 32'h1); tick();

    // mret beats a same-cycle mstatus write.
    op(2'b01, 1'b0, 12'h300, 32'h0, 5'd0); mret = 1'b1;
    push("mret_cycle_rdata", SEL_RDATA, 32'h0000_1880); tick();
    rd(12'h300);
    push("mret_mie", SEL_MIE, 32'h1); push("mret_mstatus", SEL_RDATA, 32'h0000_1888); tick();

    // Asynchronous reset mid-operation discards the pending write.
    op(2'b01, 1'b0, 12'h340, 32'h0000_0077, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    rd(12'h340);
    push("arst_epc", SEL_EPC, 32'h0); push("arst_mie", SEL_MIE, 32'h0);
    push("arst_tvec", SEL_TVEC, MTVEC_RST); push("arst_rdata", SEL_RDATA, 32'h0);
    @(negedge clk);
    drain();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(12'h340); push("arst_mscratch", SEL_RDATA, 32'h0); tick();
    rd(12'hB00); push("arst_mcycle", SEL_RDATA, cyc); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
